// File: rtl/prog_pulse_seq_pkg.sv
// Shared definitions for the programming-pulse sequencer: op codes, FSM
// encoding and default phase timings (24 MHz oscillator domain).
package prog_pulse_pkg;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_SET_PROG   = 3'd1;
    localparam logic [2:0] OP_CLR_PROG   = 3'd2;
    localparam logic [2:0] OP_PULSE_WAIT = 3'd3;
    localparam logic [2:0] OP_PULSE      = 3'd4;
    localparam logic [2:0] OP_SET_VPP    = 3'd5;
    localparam logic [2:0] OP_CLR_VPP    = 3'd6;

    localparam int DEF_DELAY_W  = 16;
    localparam int DEF_COUNT_W  = 4;
    localparam int DEF_PRE_DLY  = 48;
    localparam int DEF_POST_DLY = 48;
    localparam int DEF_POLL_DLY = 80;
    localparam int DEF_POLL_MAX = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_LOW  = 3'd2,
        ST_POST = 3'd3,
        ST_POLL = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    function automatic logic is_pulse_op(input logic [2:0] op);
        return (op == OP_PULSE) || (op == OP_PULSE_WAIT);
    endfunction

endpackage

// File: rtl/prog_pulse_seq_if.sv
// Command/status bundle between the host glue (master) and the sequencer (slave).
interface prog_pulse_seq_if
    import prog_pulse_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int COUNT_W = DEF_COUNT_W
) ();

    // Handshake: cmd_start is a one-cycle strobe, taken only while busy=0
    // (abort in the same cycle cancels it); every accepted command retires
    // with exactly one done pulse unless rst discards it.
    logic               cmd_start;
    logic [2:0]         cmd_op;
    logic [COUNT_W-1:0] cmd_npulses;
    logic [DELAY_W-1:0] cfg_width;
    logic               ready_pol;
    logic               ready_in;
    logic               abort;

    logic               prog_out;
    logic               vpp_out;
    logic               busy;
    logic               done;
    logic               err;
    logic [COUNT_W-1:0] pulses_done;

    modport master (
        output cmd_start, cmd_op, cmd_npulses, cfg_width, ready_pol, ready_in, abort,
        input  prog_out, vpp_out, busy, done, err, pulses_done
    );

    modport slave (
        input  cmd_start, cmd_op, cmd_npulses, cfg_width, ready_pol, ready_in, abort,
        output prog_out, vpp_out, busy, done, err, pulses_done
    );

endinterface

// File: rtl/prog_pulse_seq_timer.sv
// Load/count-down phase timer; a phase loaded with N-1 lasts exactly N cycles.
module prog_delay_timer #(
    parameter int DELAY_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    output logic               zero
);

    logic [DELAY_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DELAY_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/prog_pulse_seq.sv
// nPROG/VPP programming sequencer: static pin ops and N-pulse trains with
// optional ready polling after each pulse.
module prog_pulse_seq
    import prog_pulse_pkg::*;
#(
    parameter int DELAY_W  = DEF_DELAY_W,
    parameter int COUNT_W  = DEF_COUNT_W,
    parameter int PRE_DLY  = DEF_PRE_DLY,
    parameter int POST_DLY = DEF_POST_DLY,
    parameter int POLL_DLY = DEF_POLL_DLY,
    parameter int POLL_MAX = DEF_POLL_MAX
) (
    input  logic             osc,
    input  logic             rst,
    prog_pulse_seq_if.slave  bus,
    output state_t           dbg_state
);

    localparam logic [DELAY_W-1:0] PRE_M1    = DELAY_W'(PRE_DLY - 1);
    localparam logic [DELAY_W-1:0] POST_M1   = DELAY_W'(POST_DLY - 1);
    localparam logic [DELAY_W-1:0] POLL_M1   = DELAY_W'(POLL_DLY - 1);
    localparam logic [COUNT_W-1:0] POLL_LAST = COUNT_W'(POLL_MAX - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

    state_t             state_q, state_d;
    logic               tmr_load, tmr_zero;
    logic [DELAY_W-1:0] tmr_val;

    logic               prog_q, vpp_q, err_q, done_imm_q, wait_q;
    logic [COUNT_W-1:0] pulses_q, left_q, poll_q;
    logic [DELAY_W-1:0] width_m1_q;

    logic start_ok, abort_busy, ready_match;

    assign start_ok    = (state_q == ST_IDLE) && bus.cmd_start && !bus.abort;
    assign abort_busy  = (state_q != ST_IDLE) && bus.abort;
    assign ready_match = (bus.ready_in == bus.ready_pol);

    prog_delay_timer #(.DELAY_W(DELAY_W)) u_timer (
        .clk      (osc),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge osc) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // left_q is already decremented when POLL decides, so zero means "last pulse done".
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: if (start_ok && is_pulse_op(bus.cmd_op)) begin
                state_d  = ST_PRE;
                tmr_load = 1'b1;
                tmr_val  = PRE_M1;
            end
            ST_PRE: if (tmr_zero) begin
                state_d  = ST_LOW;
                tmr_load = 1'b1;
                tmr_val  = width_m1_q;
            end
            ST_LOW: if (tmr_zero) begin
                state_d  = ST_POST;
                tmr_load = 1'b1;
                tmr_val  = POST_M1;
            end
            ST_POST: if (tmr_zero) begin
                if (wait_q) begin
                    state_d  = ST_POLL;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end else if (left_q != COUNT_ONE) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = width_m1_q;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_POLL: if (tmr_zero) begin
                if (ready_match) begin
                    if (left_q != '0) begin
                        state_d  = ST_LOW;
                        tmr_load = 1'b1;
                        tmr_val  = width_m1_q;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else if (poll_q == POLL_LAST) begin
                    state_d = ST_FIN;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = POLL_M1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_busy) begin
            state_d  = (state_q == ST_FIN) ? ST_IDLE : ST_FIN;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            prog_q     <= 1'b0;
            vpp_q      <= 1'b0;
            err_q      <= 1'b0;
            done_imm_q <= 1'b0;
            wait_q     <= 1'b0;
            pulses_q   <= '0;
            left_q     <= '0;
            poll_q     <= '0;
            width_m1_q <= '0;
        end else begin
            done_imm_q <= 1'b0;
            if (start_ok) begin
                err_q      <= 1'b0;
                pulses_q   <= '0;
                poll_q     <= '0;
                done_imm_q <= !is_pulse_op(bus.cmd_op);
                wait_q     <= (bus.cmd_op == OP_PULSE_WAIT);
                width_m1_q <= (bus.cfg_width == '0) ? '0 : bus.cfg_width - DELAY_W'(1);
                left_q     <= (bus.cmd_npulses == '0) ? COUNT_ONE : bus.cmd_npulses;
                case (bus.cmd_op)
                    OP_SET_PROG, OP_PULSE, OP_PULSE_WAIT: prog_q <= 1'b1;
                    OP_CLR_PROG:                          prog_q <= 1'b0;
                    OP_SET_VPP:                           vpp_q  <= 1'b1;
                    OP_CLR_VPP:                           vpp_q  <= 1'b0;
                    default: ;
                endcase
            end else if (abort_busy) begin
                prog_q <= 1'b1;
                vpp_q  <= 1'b0;
                err_q  <= 1'b1;
            end else if (state_q != ST_IDLE) begin
                prog_q <= (state_d != ST_LOW);
                if (state_q == ST_POST && tmr_zero) begin
                    if (pulses_q != '1) pulses_q <= pulses_q + COUNT_ONE;
                    left_q <= left_q - COUNT_ONE;
                    poll_q <= '0;
                end
                if (state_q == ST_POLL && tmr_zero && !ready_match) begin
                    poll_q <= poll_q + COUNT_ONE;
                    if (poll_q == POLL_LAST) err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.prog_out    = prog_q;
        bus.vpp_out     = vpp_q;
        bus.busy        = (state_q != ST_IDLE);
        bus.done        = done_imm_q || (state_q == ST_FIN);
        bus.err         = err_q;
        bus.pulses_done = pulses_q;
        dbg_state       = state_q;
    end

endmodule

// File: doc/prog_pulse_seq.md
Name: prog_pulse_seq

Overview:
Parametrised successor to the single-shot nPROG sequencer used by the DIP40 microcontroller bottomhalves. It runs in the oscillator domain and executes programming commands. Supported: static PROG/VPP set/clear, N-pulse trains, and N-pulse trains with ready polling after each pulse. Pulse width and ready polarity are selected at run time. The host-interface glue synchronises command starts into this domain; prog_out and vpp_out drive the ZIF pin buffers.

Parameters:
DELAY_W, 16, width of the phase delay counter
COUNT_W, 4, width of the pulse-count and poll-count fields
PRE_DLY, 48, cycles PROG is held high before the first pulse (2 us at 24 MHz)
POST_DLY, 48, cycles PROG is held high after each pulse
POLL_DLY, 80, cycles between ready samples
POLL_MAX, 12, maximum ready samples per pulse before error

Ports:
osc  in  1  24 MHz oscillator; sole clock
rst  in  1  synchronous active-high reset
cmd_start  in  1  single-cycle command strobe
cmd_op  in  3  0 NOP, 1 SET_PROG, 2 CLR_PROG, 3 PULSE_WAIT, 4 PULSE, 5 SET_VPP, 6 CLR_VPP, 7 NOP
cmd_npulses  in  COUNT_W  pulses per train; 0 is treated as 1
cfg_width  in  DELAY_W  low-phase length in cycles; 0 is treated as 1
ready_pol  in  1  level of ready_in that means ready
ready_in  in  1  DUT ready/busy pin (P3.0); already synchronised
abort  in  1  terminate the running command
prog_out  out  1  nPROG drive level
vpp_out  out  1  VPP enable
busy  out  1  a command is running
done  out  1  one-cycle completion pulse
err  out  1  sticky error: poll timeout or abort
pulses_done  out  COUNT_W  pulses completed in the current or last command

Behaviour:
- Reset: prog_out=0, vpp_out=0, busy=0, done=0, err=0, pulses_done=0, FSM=IDLE. Reset mid-command discards the command with no done pulse.
- Command inputs are sampled only when cmd_start=1 in IDLE. cmd_start while busy is ignored. If cmd_start and abort are both high in the same cycle, abort wins and the start is ignored.
- Every start clears err and pulses_done.
- SET/CLR ops: the output changes in cycle t+1 (start sampled at edge t). done=1 in cycle t+1. busy never asserts.
- NOP: done=1 in cycle t+1; no output changes.
- PULSE and PULSE_WAIT FSM states: PRE, LOW, POST, POLL, FIN.
- PRE: prog_out=1 from t+1 for PRE_DLY cycles.
- LOW: prog_out=0 for exactly W cycles, where W = max(cfg_width, 1) latched at start.
- POST: prog_out=1 for POST_DLY cycles. At the end of POST, pulses_done increments.
- After POST:
  - PULSE, more pulses remaining: go to LOW. PRE is not repeated, so the inter-pulse gap equals POST_DLY.
  - PULSE_WAIT: go to POLL.
  - Last pulse: go to FIN.
- POLL:
  - Sample ready_in. On a match with ready_pol, continue to the next pulse or to FIN.
  - Otherwise wait POLL_DLY cycles and resample.
  - After POLL_MAX non-matching samples: err=1, remaining pulses are skipped, go to FIN.
- FIN lasts one cycle: done=1, busy drops to 0 in the next cycle. busy is high from t+1 through the FIN cycle.
- Single PULSE with defaults: prog_out falls at t+49, rises at t+49+W, done at t+97+W.
- abort while busy: next cycle prog_out=1, vpp_out=0, err=1, then FIN. abort in IDLE is ignored.
- Delay counter: loads (N-1) on phase entry and advances the phase at 0, so each phase lasts exactly N cycles.
- pulses_done saturates at 2^COUNT_W-1.

Decomposition:
- Package prog_pulse_pkg holds the op code localparams, the FSM state encoding, and the default delay constants.
- One sub-module, prog_delay_timer: load/count-down/zero-flag timer of width DELAY_W, instanced once and shared by all phases.

Test Plan:
- SET_VPP then SET_PROG -> vpp_out=1 at t+1, prog_out=1 at t+1; done pulses each time; busy stays 0.
- PULSE, npulses=1, cfg_width=24 -> prog_out low cycles t+49..t+72, done at t+121, pulses_done=1, err=0.
- PULSE, npulses=3, cfg_width=10 -> three low windows, each 10 cycles, separated by 48 high cycles; pulses_done=3.
- PULSE_WAIT, ready_pol=1, ready_in goes high after 3 polls -> done with err=0, poll spacing 80 cycles.
- PULSE_WAIT, ready_in stuck 0, npulses=2 -> 12 samples, then err=1, pulses_done=1, second pulse never issued.
- abort during LOW, plus a cmd_start collision and rst during POLL -> prog_out=1, vpp_out=0, err=1, done once; the collided start is ignored; rst returns all outputs to reset values with no done.
